// File: rtl/twowire_pkg.sv
// Shared constants, encodings and frame helpers for the two-wire debug host.
package twowire_pkg;

  localparam logic [31:0]  TWD_CONNECT_MAGIC  = 32'ha7a3_6fc5;
  localparam int unsigned  TWD_PREAMBLE_LEN   = 8;
  localparam int unsigned  TWD_CONNECT_LEN    = TWD_PREAMBLE_LEN + 32 + 4;

  localparam logic [3:0]   TWD_CMD_DISCONNECT = 4'h0;
  localparam logic [3:0]   TWD_CMD_WRITE      = 4'h2;
  localparam logic [3:0]   TWD_CMD_READ       = 4'h3;

  // Wide enough for the largest header (start + cmd + 64-bit addr + parity).
  localparam int unsigned  TWD_SR_W  = 72;
  localparam int unsigned  TWD_CNT_W = 7;

  typedef enum logic [1:0] {
    OP_CONNECT    = 2'd0,
    OP_DISCONNECT = 2'd1,
    OP_READ       = 2'd2,
    OP_WRITE      = 2'd3
  } twd_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CONN,
    ST_HDR,
    ST_WDATA,
    ST_TURN1,
    ST_RDATA,
    ST_RPAR,
    ST_TURN2,
    ST_RESP
  } twd_state_e;

  function automatic logic [TWD_SR_W-1:0] connect_frame(input logic [3:0] dropaddr);
    return {28'h0, dropaddr, TWD_CONNECT_MAGIC, {TWD_PREAMBLE_LEN{1'b1}}};
  endfunction

endpackage

// File: rtl/twowire_host_shifter.sv
// Load / shift register with a down-counting bit counter; bits leave at [0],
// DIO samples enter at [W-1] so a 32-bit read lands LSB-first in the top word.
module twowire_host_shifter
  import twowire_pkg::*;
#(
  parameter int unsigned W = TWD_SR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [W-1:0]         load_data_i,
  input  logic [TWD_CNT_W-1:0] load_cnt_i,
  input  logic                 shift_i,
  input  logic                 sin_i,
  output logic                 bit_o,
  output logic [31:0]          rdata_o,
  output logic [TWD_CNT_W-1:0] cnt_o
);

  logic [W-1:0]         sr_q, sr_d;
  logic [TWD_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = load_data_i;
      cnt_d = load_cnt_i;
    end else if (shift_i) begin
      sr_d = {sin_i, sr_q[W-1:1]};
      if (cnt_q != '0) cnt_d = cnt_q - TWD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_o   = sr_q[0];
  assign rdata_o = sr_q[W-1 -: 32];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/twowire_host.sv
// Two-wire debug host: CONNECT/DISCONNECT/READ/WRITE framing over one DIO line.
// Optional parity via TWOWIRE_PARITY_EN. DIO output port is do_o ('do' is reserved).
module twowire_host
  import twowire_pkg::*;
#(
  parameter int unsigned ASIZE = 0
) (
  input  logic                    dck,
  input  logic                    drst_n,
  output logic                    do_o,
  output logic                    doe,
  input  logic                    di,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [8*(1+ASIZE)-1:0]  req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_err,
  output logic                    connected
);

  localparam int unsigned AW = 8 * (1 + ASIZE);
`ifdef TWOWIRE_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif

  // Counter values are "bits remaining after the one on the line".
  localparam logic [TWD_CNT_W-1:0] CONN_LAST  = TWD_CNT_W'(TWD_CONNECT_LEN - 1);
  localparam logic [TWD_CNT_W-1:0] HDRA_LAST  = TWD_CNT_W'(4 + AW + PB);
  localparam logic [TWD_CNT_W-1:0] HDRD_LAST  = TWD_CNT_W'(4 + PB);
  localparam logic [TWD_CNT_W-1:0] DATA_LAST  = TWD_CNT_W'(31 + PB);
  localparam logic [TWD_CNT_W-1:0] RDATA_LAST = TWD_CNT_W'(31);

  twd_state_e  state_q, state_d;
  twd_op_e     op_q, op_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        conn_q, conn_d;
  logic        err_q, err_d;
  logic        do_q, do_d;
  logic        doe_q, doe_d;
  logic        ready_q, ready_d;
`ifdef TWOWIRE_PARITY_EN
  logic        par_q, par_d;
`endif

  logic [TWD_SR_W-1:0]  frame;
  logic                 ld, sh;
  logic [TWD_CNT_W-1:0] ld_cnt;
  logic                 sr_bit;
  logic [31:0]          sr_rdata;
  logic [TWD_CNT_W-1:0] cnt;

  function automatic logic [TWD_SR_W-1:0] hdr_frame(input logic [3:0]    cmd,
                                                    input logic [AW-1:0] addr,
                                                    input logic          with_addr);
    logic [TWD_SR_W-1:0] f;
    f      = '0;
    f[0]   = 1'b1;
    f[4:1] = cmd;
    if (with_addr) begin
      f[4+AW:5] = addr;
`ifdef TWOWIRE_PARITY_EN
      f[5+AW] = ^{cmd, addr};
`endif
    end else begin
`ifdef TWOWIRE_PARITY_EN
      f[5] = ^cmd;
`endif
    end
    return f;
  endfunction

  function automatic logic [TWD_SR_W-1:0] data_frame(input logic [31:0] d);
    logic [TWD_SR_W-1:0] f;
    f       = '0;
    f[31:0] = d;
`ifdef TWOWIRE_PARITY_EN
    f[32] = ^d;
`endif
    return f;
  endfunction

  // Whenever a segment is loaded its bit 0 goes straight to the do flop,
  // so the shifter only ever holds the bits still to come.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    conn_d  = conn_q;
    err_d   = err_q;
    do_d    = 1'b0;
    doe_d   = 1'b1;
    frame   = '0;
    ld      = 1'b0;
    ld_cnt  = '0;
    sh      = 1'b0;
`ifdef TWOWIRE_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          op_d    = twd_op_e'(req_op);
          wdata_d = req_wdata;
          err_d   = 1'b0;
          rdata_d = '0;
          if (op_d == OP_CONNECT) begin
            frame   = connect_frame(req_addr[3:0]);
            ld      = 1'b1;
            ld_cnt  = CONN_LAST;
            do_d    = frame[0];
            state_d = ST_CONN;
          end else if (!conn_q) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            frame  = hdr_frame((op_d == OP_READ)  ? TWD_CMD_READ  :
                               (op_d == OP_WRITE) ? TWD_CMD_WRITE : TWD_CMD_DISCONNECT,
                               req_addr, op_d != OP_DISCONNECT);
            ld      = 1'b1;
            ld_cnt  = (op_d == OP_DISCONNECT) ? HDRD_LAST : HDRA_LAST;
            do_d    = frame[0];
            state_d = ST_HDR;
          end
        end
      end
      ST_CONN: begin
        if (cnt == '0) begin
          conn_d  = 1'b1;
          state_d = ST_RESP;
        end else begin
          sh   = 1'b1;
          do_d = sr_bit;
        end
      end
      ST_HDR: begin
        if (cnt == '0) begin
          unique case (op_q)
            OP_WRITE: begin
              frame   = data_frame(wdata_q);
              ld      = 1'b1;
              ld_cnt  = DATA_LAST;
              do_d    = frame[0];
              state_d = ST_WDATA;
            end
            OP_READ: begin
              doe_d   = 1'b0;
              state_d = ST_TURN1;
            end
            default: begin
              conn_d  = 1'b0;
              state_d = ST_RESP;
            end
          endcase
        end else begin
          sh   = 1'b1;
          do_d = sr_bit;
        end
      end
      ST_WDATA: begin
        if (cnt == '0) begin
          state_d = ST_RESP;
        end else begin
          sh   = 1'b1;
          do_d = sr_bit;
        end
      end
      ST_TURN1: begin
        doe_d   = 1'b0;
        ld      = 1'b1;
        ld_cnt  = RDATA_LAST;
        state_d = ST_RDATA;
      end
      ST_RDATA: begin
        doe_d = 1'b0;
        sh    = 1'b1;
        if (cnt == '0) begin
`ifdef TWOWIRE_PARITY_EN
          state_d = ST_RPAR;
`else
          state_d = ST_TURN2;
`endif
        end
      end
      ST_RPAR: begin
`ifdef TWOWIRE_PARITY_EN
        par_d   = di;
`endif
        doe_d   = 1'b0;
        state_d = ST_TURN2;
      end
      ST_TURN2: begin
        rdata_d = sr_rdata;
`ifdef TWOWIRE_PARITY_EN
        err_d   = (^sr_rdata) != par_q;
`endif
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge dck) begin
    if (!drst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_CONNECT;
      wdata_q <= '0;
      rdata_q <= '0;
      conn_q  <= 1'b0;
      err_q   <= 1'b0;
      do_q    <= 1'b0;
      doe_q   <= 1'b0;
      ready_q <= 1'b0;
`ifdef TWOWIRE_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      conn_q  <= conn_d;
      err_q   <= err_d;
      do_q    <= do_d;
      doe_q   <= doe_d;
      ready_q <= ready_d;
`ifdef TWOWIRE_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  twowire_host_shifter #(.W(TWD_SR_W)) u_shifter (
    .clk_i       (dck),
    .rst_ni      (drst_n),
    .load_i      (ld),
    .load_data_i (frame >> 1),
    .load_cnt_i  (ld_cnt),
    .shift_i     (sh),
    .sin_i       (di),
    .bit_o       (sr_bit),
    .rdata_o     (sr_rdata),
    .cnt_o       (cnt)
  );

  assign do_o       = do_q;
  assign doe        = doe_q;
  assign req_ready  = ready_q;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign connected  = conn_q;

endmodule

// File: tb/tb_twowire_host.sv
// Directed bench for twowire_host (ASIZE=0) with an inline target DTM model
// driving di during read data/parity cycles.
module tb_twowire_host;

`ifdef TWOWIRE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic        dck = 1'b0;
  logic        drst_n = 1'b0;
  logic        do_o, doe, di = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [7:0]  req_addr = 8'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid, resp_err, connected;
  logic [31:0] resp_rdata;

  int checks = 0;
  int failures = 0;

  twowire_host #(.ASIZE(0)) dut (
    .dck(dck), .drst_n(drst_n), .do_o(do_o), .doe(doe), .di(di),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .connected(connected)
  );

  always #5 dck = ~dck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge dck);
    #1;
  endtask

  // Present a request for one cycle, then scramble the request fields.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [31:0] wd);
    req_op = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_op = ~op; req_addr = ~a; req_wdata = ~wd;
  endtask

  task automatic test_reset();
    drst_n = 1'b0;
    tick(); tick();
    checks++; if ({do_o, doe, req_ready, resp_valid, resp_err, connected} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl: got do/doe/rdy/rv/err/conn=%b want 000000",
                           {do_o, doe, req_ready, resp_valid, resp_err, connected});
    end
    checks++; if (resp_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got %h want 00000000", resp_rdata);
    end
    drst_n = 1'b1;
    tick();
    checks++; if ({doe, req_ready, do_o} !== 3'b110) begin
      failures++; $display("FAIL reset_release: got doe/rdy/do=%b want 110", {doe, req_ready, do_o});
    end
  endtask

  task automatic test_not_connected();
    checks++; if (req_ready !== 1'b1) begin
      failures++; $display("FAIL nc_ready: got %b want 1", req_ready);
    end
    issue(2'd3, 8'h10, 32'hdeadbeef);
    checks++; if ({resp_valid, resp_err, doe, do_o} !== 4'b1110) begin
      failures++; $display("FAIL nc_resp: got rv/err/doe/do=%b want 1110", {resp_valid, resp_err, doe, do_o});
    end
    checks++; if (resp_rdata !== 32'h0) begin
      failures++; $display("FAIL nc_rdata: got %h want 00000000", resp_rdata);
    end
    tick();
    checks++; if ({resp_valid, req_ready, do_o, connected} !== 4'b0100) begin
      failures++; $display("FAIL nc_after: got rv/rdy/do/conn=%b want 0100", {resp_valid, req_ready, do_o, connected});
    end
  endtask

  task automatic test_connect(input logic [3:0] a);
    logic [43:0] exp;
    exp = {a, 32'ha7a36fc5, 8'hff};
    checks++; if (req_ready !== 1'b1) begin
      failures++; $display("FAIL conn_ready: got %b want 1", req_ready);
    end
    issue(2'd0, {4'h0, a}, 32'h0);
    for (int k = 0; k < 44; k++) begin
      checks++; if ({doe, do_o, resp_valid} !== {1'b1, exp[k], 1'b0}) begin
        failures++; $display("FAIL conn_bit%0d: got doe/do/rv=%b want %b", k,
                             {doe, do_o, resp_valid}, {1'b1, exp[k], 1'b0});
      end
      tick();
    end
    checks++; if ({resp_valid, connected, resp_err} !== 3'b110) begin
      failures++; $display("FAIL conn_resp: got rv/conn/err=%b want 110", {resp_valid, connected, resp_err});
    end
    tick();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin
      failures++; $display("FAIL conn_idle: got rv/rdy=%b want 01", {resp_valid, req_ready});
    end
  endtask

  task automatic test_write();
    logic [63:0] exp;
    int len;
`ifdef TWOWIRE_PARITY_EN
    exp = {17'h0, 1'b0, 32'hdeadbeef, 1'b0, 8'h10, 4'h2, 1'b1};
`else
    exp = {19'h0, 32'hdeadbeef, 8'h10, 4'h2, 1'b1};
`endif
    len = 45 + 2 * PB;
    issue(2'd3, 8'h10, 32'hdeadbeef);
    for (int k = 0; k < len; k++) begin
      checks++; if ({doe, do_o, resp_valid} !== {1'b1, exp[k], 1'b0}) begin
        failures++; $display("FAIL wr_bit%0d: got doe/do/rv=%b want %b", k,
                             {doe, do_o, resp_valid}, {1'b1, exp[k], 1'b0});
      end
      tick();
    end
    checks++; if ({resp_valid, resp_err, connected} !== 3'b101 || resp_rdata !== 32'h0) begin
      failures++; $display("FAIL wr_resp: got rv/err/conn=%b rdata=%h want 101 00000000",
                           {resp_valid, resp_err, connected}, resp_rdata);
    end
    tick();
  endtask

  task automatic test_read(input logic [31:0] d, input logic bad_par);
    logic [63:0] exp;
    logic        exp_err;
    int          h;
    int          zeros;
`ifdef TWOWIRE_PARITY_EN
    exp     = {50'h0, 1'b1, 8'h04, 4'h3, 1'b1};
    exp_err = bad_par;
`else
    exp     = {51'h0, 8'h04, 4'h3, 1'b1};
    exp_err = 1'b0;
`endif
    h = 13 + PB;
    zeros = 0;
    issue(2'd2, 8'h04, 32'h0);
    for (int c = 1; c <= h; c++) begin
      checks++; if ({doe, do_o} !== {1'b1, exp[c-1]}) begin
        failures++; $display("FAIL rd_hdr%0d: got doe/do=%b want %b", c - 1, {doe, do_o}, {1'b1, exp[c-1]});
      end
      tick();
    end
    for (int c = h + 1; c <= h + 34 + PB; c++) begin
      if (doe === 1'b0 && resp_valid === 1'b0) zeros++;
      if (c >= h + 2 && c <= h + 33) di = d[c-h-2];
`ifdef TWOWIRE_PARITY_EN
      if (c == h + 34) di = (^d) ^ bad_par;
`endif
      tick();
    end
    di = 1'b0;
    checks++; if (zeros !== 34 + PB) begin
      failures++; $display("FAIL rd_turn: got %0d released cycles want %0d", zeros, 34 + PB);
    end
    checks++; if ({resp_valid, doe, resp_err} !== {2'b11, exp_err}) begin
      failures++; $display("FAIL rd_resp: got rv/doe/err=%b want %b", {resp_valid, doe, resp_err}, {2'b11, exp_err});
    end
    checks++; if (resp_rdata !== d) begin
      failures++; $display("FAIL rd_data: got %h want %h", resp_rdata, d);
    end
    tick();
    checks++; if ({resp_valid, req_ready, connected} !== 3'b011) begin
      failures++; $display("FAIL rd_after: got rv/rdy/conn=%b want 011", {resp_valid, req_ready, connected});
    end
  endtask

  task automatic test_disconnect();
    logic [7:0] exp;
    int len;
`ifdef TWOWIRE_PARITY_EN
    exp = {2'b0, 1'b0, 4'h0, 1'b1};
`else
    exp = {3'b0, 4'h0, 1'b1};
`endif
    len = 5 + PB;
    issue(2'd1, 8'h55, 32'h0);
    for (int k = 0; k < len; k++) begin
      checks++; if ({doe, do_o, connected} !== {1'b1, exp[k], 1'b1}) begin
        failures++; $display("FAIL dis_bit%0d: got doe/do/conn=%b want %b", k,
                             {doe, do_o, connected}, {1'b1, exp[k], 1'b1});
      end
      tick();
    end
    checks++; if ({resp_valid, connected, resp_err} !== 3'b100) begin
      failures++; $display("FAIL dis_resp: got rv/conn/err=%b want 100", {resp_valid, connected, resp_err});
    end
    tick();
    issue(2'd2, 8'h04, 32'h0);
    checks++; if ({resp_valid, resp_err, doe, do_o} !== 4'b1110 || resp_rdata !== 32'h0) begin
      failures++; $display("FAIL dis_rd_nc: got rv/err/doe/do=%b rdata=%h want 1110 00000000",
                           {resp_valid, resp_err, doe, do_o}, resp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    int rv_seen;
    test_connect(4'h3);
    issue(2'd3, 8'h10, 32'hdeadbeef);
    for (int k = 1; k < 20; k++) tick();
    drst_n = 1'b0;
    tick();
    checks++; if ({doe, do_o, connected, resp_valid, req_ready} !== 5'b0) begin
      failures++; $display("FAIL rst_mid: got doe/do/conn/rv/rdy=%b want 00000",
                           {doe, do_o, connected, resp_valid, req_ready});
    end
    tick();
    drst_n = 1'b1;
    rv_seen = 0;
    tick();
    checks++; if ({doe, req_ready, connected} !== 3'b110) begin
      failures++; $display("FAIL rst_mid_release: got doe/rdy/conn=%b want 110", {doe, req_ready, connected});
    end
    for (int k = 0; k < 40; k++) begin
      if (resp_valid !== 1'b0) rv_seen++;
      tick();
    end
    checks++; if (rv_seen !== 0) begin
      failures++; $display("FAIL rst_mid_noresp: got %0d resp_valid cycles want 0", rv_seen);
    end
    test_connect(4'h0);
  endtask

  initial begin
    test_reset();
    test_not_connected();
    test_connect(4'h0);
    test_connect(4'h5);
    test_write();
    test_read(32'h12345678, 1'b0);
    test_read(32'h12345678, 1'b1);
    test_read(32'h8000_0001, 1'b0);
    test_disconnect();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
